// File: rtl/id_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// The stage itself connects through the slave modport; the environment
// (fetch + execute) connects through the master modport.
interface id_stage_if #(
    parameter int DATA_WIDTH             = 32,
    parameter int REGISTER_ADDRESS_WIDTH = 5,
    parameter int PC_WIDTH               = 32
);
    // fetch -> decode
    logic                              in_valid;
    logic                              in_ready;
    logic [31:0]                       in_instr;
    logic [PC_WIDTH-1:0]               in_pc;
    // decode -> execute
    logic                              out_valid;
    logic                              out_ready;
    logic [PC_WIDTH-1:0]               out_pc;
    logic [REGISTER_ADDRESS_WIDTH-1:0] out_rd;
    logic [DATA_WIDTH-1:0]             out_imm;
    logic [3:0]                        out_op_class;
    logic [2:0]                        out_funct3;
    logic                              out_funct7_5;
    logic                              out_illegal;
    logic [DATA_WIDTH-1:0]             out_op_a;
    logic [DATA_WIDTH-1:0]             out_op_b;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_rd, out_imm, out_op_class,
               out_funct3, out_funct7_5, out_illegal, out_op_a, out_op_b
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_rd, out_imm, out_op_class,
               out_funct3, out_funct7_5, out_illegal, out_op_a, out_op_b
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: one-entry stage register between fetch and execute,
// register file address generation, and a one-cycle writeback bypass that
// covers the register file's read-before-write behaviour.
module id_stage #(
    parameter int DATA_WIDTH             = 32,
    parameter int REGISTER_ADDRESS_WIDTH = 5,
    parameter int PC_WIDTH               = 32
) (
    input  logic                              clk,
    input  logic                              a_reset_n,
    input  logic                              flush,
    id_stage_if.slave                         bus,
    output logic [REGISTER_ADDRESS_WIDTH-1:0] rf_addr1,
    output logic [REGISTER_ADDRESS_WIDTH-1:0] rf_addr2,
    input  logic [DATA_WIDTH-1:0]             rf_data1,
    input  logic [DATA_WIDTH-1:0]             rf_data2,
    input  logic                              wb_we,
    input  logic [REGISTER_ADDRESS_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0]             wb_data
);
    typedef enum logic [3:0] {
        CLS_OP      = 4'd0,
        CLS_OP_IMM  = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_FENCE   = 4'd9,
        CLS_SYSTEM  = 4'd10,
        CLS_ILLEGAL = 4'd15
    } op_class_t;

    // incoming instruction and its immediate formats
    logic [31:0] ins;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign ins   = bus.in_instr;
    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

    // decoded view of the incoming instruction
    op_class_t                         d_class;
    logic                              d_illegal;
    logic [31:0]                       d_imm32;
    logic [REGISTER_ADDRESS_WIDTH-1:0] d_rs1, d_rs2, d_rd;

    // stage register s1
    logic                              s1_valid;
    logic [PC_WIDTH-1:0]               s1_pc;
    logic [REGISTER_ADDRESS_WIDTH-1:0] s1_rd, s1_rs1, s1_rs2;
    logic [DATA_WIDTH-1:0]             s1_imm;
    op_class_t                         s1_class;
    logic [2:0]                        s1_funct3;
    logic                              s1_funct7_5;
    logic                              s1_illegal;

    // writeback bypass registers
    logic                              byp_a_valid, byp_b_valid;
    logic [DATA_WIDTH-1:0]             byp_a_data, byp_b_data;

    logic in_ready_i;
    logic accept;

    // classify the opcode, pick the immediate format and mask unused register fields
    always_comb begin
        d_class   = CLS_ILLEGAL;
        d_illegal = 1'b0;
        d_imm32   = '0;
        case (ins[6:0])
            7'b0110011: d_class = CLS_OP;
            7'b0010011: begin d_class = CLS_OP_IMM; d_imm32 = imm_i; end
            7'b0000011: begin d_class = CLS_LOAD;   d_imm32 = imm_i; end
            7'b0100011: begin d_class = CLS_STORE;  d_imm32 = imm_s; end
            7'b1100011: begin d_class = CLS_BRANCH; d_imm32 = imm_b; end
            7'b1101111: begin d_class = CLS_JAL;    d_imm32 = imm_j; end
            7'b1100111: begin d_class = CLS_JALR;   d_imm32 = imm_i; end
            7'b0110111: begin d_class = CLS_LUI;    d_imm32 = imm_u; end
            7'b0010111: begin d_class = CLS_AUIPC;  d_imm32 = imm_u; end
            7'b0001111: begin d_class = CLS_FENCE;  d_imm32 = imm_i; end
            7'b1110011: begin d_class = CLS_SYSTEM; d_imm32 = imm_i; end
            default:    begin d_class = CLS_ILLEGAL; d_illegal = 1'b1; end
        endcase

        d_rs1 = REGISTER_ADDRESS_WIDTH'(ins[19:15]);
        d_rs2 = REGISTER_ADDRESS_WIDTH'(ins[24:20]);
        d_rd  = REGISTER_ADDRESS_WIDTH'(ins[11:7]);
        if (d_class inside {CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_ILLEGAL})
            d_rs1 = '0;
        if (!(d_class inside {CLS_OP, CLS_STORE, CLS_BRANCH}))
            d_rs2 = '0;
        if (d_class inside {CLS_STORE, CLS_BRANCH, CLS_FENCE, CLS_ILLEGAL})
            d_rd = '0;
    end

    assign in_ready_i   = !s1_valid || bus.out_ready;
    assign bus.in_ready = in_ready_i;
    assign accept       = bus.in_valid && in_ready_i && !flush;

    // a held instruction keeps re-reading its sources so the operands track writebacks
    assign rf_addr1 = accept ? d_rs1 : s1_rs1;
    assign rf_addr2 = accept ? d_rs2 : s1_rs2;

    // stage register: flush beats accept, accept beats drain, otherwise hold
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            s1_valid    <= 1'b0;
            s1_pc       <= '0;
            s1_rd       <= '0;
            s1_rs1      <= '0;
            s1_rs2      <= '0;
            s1_imm      <= '0;
            s1_class    <= CLS_OP;
            s1_funct3   <= '0;
            s1_funct7_5 <= 1'b0;
            s1_illegal  <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid    <= 1'b1;
            s1_pc       <= bus.in_pc;
            s1_rd       <= d_rd;
            s1_rs1      <= d_rs1;
            s1_rs2      <= d_rs2;
            s1_imm      <= DATA_WIDTH'($signed(d_imm32));
            s1_class    <= d_class;
            s1_funct3   <= ins[14:12];
            s1_funct7_5 <= ins[30];
            s1_illegal  <= d_illegal;
        end else if (bus.out_ready) begin
            s1_valid <= 1'b0;
        end
    end

    // capture a writeback that the register file will not yet show next cycle
    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            byp_a_valid <= 1'b0;
            byp_b_valid <= 1'b0;
            byp_a_data  <= '0;
            byp_b_data  <= '0;
        end else begin
            byp_a_valid <= wb_we && (wb_addr == rf_addr1) && (rf_addr1 != '0);
            byp_b_valid <= wb_we && (wb_addr == rf_addr2) && (rf_addr2 != '0);
            byp_a_data  <= wb_data;
            byp_b_data  <= wb_data;
        end
    end

    assign bus.out_valid    = s1_valid;
    assign bus.out_pc       = s1_pc;
    assign bus.out_rd       = s1_rd;
    assign bus.out_imm      = s1_imm;
    assign bus.out_op_class = s1_class;
    assign bus.out_funct3   = s1_funct3;
    assign bus.out_funct7_5 = s1_funct7_5;
    assign bus.out_illegal  = s1_illegal;
    assign bus.out_op_a     = byp_a_valid ? byp_a_data : rf_data1;
    assign bus.out_op_b     = byp_b_valid ? byp_b_data : rf_data2;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: register file model, queue-based reference of the
// stage contents, per-cycle comparison plus directed literal checks.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        a_reset_n;
    logic        flush;
    logic [4:0]  rf_addr1, rf_addr2;
    logic [31:0] rf_data1, rf_data2;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int vectors = 0;
    int errors  = 0;

    id_stage_if #(.DATA_WIDTH(32), .REGISTER_ADDRESS_WIDTH(5), .PC_WIDTH(32)) bus ();

    id_stage #(.DATA_WIDTH(32), .REGISTER_ADDRESS_WIDTH(5), .PC_WIDTH(32)) dut (
        .clk       (clk),
        .a_reset_n (a_reset_n),
        .flush     (flush),
        .bus       (bus),
        .rf_addr1  (rf_addr1),
        .rf_addr2  (rf_addr2),
        .rf_data1  (rf_data1),
        .rf_data2  (rf_data2),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    always #5 clk = ~clk;

    // register file: one-cycle read latency, reads see the pre-write value, x0 hardwired
    logic [31:0] regs [32] = '{default: '0};
    always @(posedge clk) begin
        rf_data1 <= regs[rf_addr1];
        rf_data2 <= regs[rf_addr2];
        if (wb_we && wb_addr != 5'd0) regs[wb_addr] <= wb_data;
    end

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [3:0]  cls;
        logic [2:0]  f3;
        logic        f7;
        logic        ill;
    } exp_t;

    exp_t q[$];

    // reference decode: immediates assembled numerically from instruction fields
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int   v;
        e.pc = pc; e.f3 = w[14:12]; e.f7 = w[30]; e.ill = 1'b0; v = 0;
        case (w[6:0])
            7'h33: e.cls = 4'd0;
            7'h13: e.cls = 4'd1;
            7'h03: e.cls = 4'd2;
            7'h23: e.cls = 4'd3;
            7'h63: e.cls = 4'd4;
            7'h6F: e.cls = 4'd5;
            7'h67: e.cls = 4'd6;
            7'h37: e.cls = 4'd7;
            7'h17: e.cls = 4'd8;
            7'h0F: e.cls = 4'd9;
            7'h73: e.cls = 4'd10;
            default: begin e.cls = 4'd15; e.ill = 1'b1; end
        endcase
        case (e.cls)
            4'd1, 4'd2, 4'd6, 4'd9, 4'd10: begin
                v = int'(w[31:20]);
                if (v >= 2048) v -= 4096;
            end
            4'd3: begin
                v = int'(w[31:25]) * 32 + int'(w[11:7]);
                if (v >= 2048) v -= 4096;
            end
            4'd4: begin
                v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            4'd7, 4'd8: v = int'(w[31:12]) * 4096;
            4'd5: begin
                v = int'(w[31]) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            default: v = 0;
        endcase
        e.imm = 32'(v);
        e.rs1 = (e.cls inside {4'd5, 4'd7, 4'd8, 4'd15}) ? 5'd0 : w[19:15];
        e.rs2 = (e.cls inside {4'd0, 4'd3, 4'd4}) ? w[24:20] : 5'd0;
        e.rd  = (e.cls inside {4'd3, 4'd4, 4'd9, 4'd15}) ? 5'd0 : w[11:7];
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: the stage holds at most one instruction; flush empties it
    always @(posedge clk) begin
        logic acc;
        if (a_reset_n) begin
            acc = bus.in_valid && (q.size() == 0 || bus.out_ready) && !flush;
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
                if (acc) q.push_back(ref_decode(bus.in_instr, bus.in_pc));
            end
        end
    end

    always @(negedge a_reset_n) q.delete();

    // compare every cycle; operands must equal the current architectural register values
    always @(negedge clk) begin
        exp_t e;
        if (q.size() == 0) begin
            check("out_valid_empty", 32'(bus.out_valid), 32'd0);
        end else begin
            e = q[0];
            check("out_valid", 32'(bus.out_valid), 32'd1);
            check("out_pc", bus.out_pc, e.pc);
            check("out_rd", 32'(bus.out_rd), 32'(e.rd));
            check("out_imm", bus.out_imm, e.imm);
            check("out_op_class", 32'(bus.out_op_class), 32'(e.cls));
            check("out_funct3", 32'(bus.out_funct3), 32'(e.f3));
            check("out_funct7_5", 32'(bus.out_funct7_5), 32'(e.f7));
            check("out_illegal", 32'(bus.out_illegal), 32'(e.ill));
            check("out_op_a", bus.out_op_a, regs[e.rs1]);
            check("out_op_b", bus.out_op_b, regs[e.rs2]);
        end
        check("in_ready", 32'(bus.in_ready), 32'(q.size() == 0 || bus.out_ready));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        bus.in_pc    = pc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_reset_n     = 1'b0;
        flush         = 1'b0;
        wb_we         = 1'b0;
        wb_addr       = '0;
        wb_data       = '0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b1;
        step(); step();
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_imm", bus.out_imm, 32'd0);
        check("rst_rd", 32'(bus.out_rd), 32'd0);
        #2 a_reset_n = 1'b1;

        // preload x1=10, x2=20
        step(); wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'd10;
        step(); wb_addr = 5'd2; wb_data = 32'd20;
        step(); wb_we = 1'b0;
        send(32'hFFF08293, 32'h100);            // addi x5,x1,-1
        step(); bus.in_valid = 1'b0;
        @(negedge clk);
        check("addi_valid", 32'(bus.out_valid), 32'd1);
        check("addi_class", 32'(bus.out_op_class), 32'd1);
        check("addi_rd", 32'(bus.out_rd), 32'd5);
        check("addi_imm", bus.out_imm, 32'hFFFFFFFF);
        check("addi_op_a", bus.out_op_a, 32'd10);
        check("addi_op_b", bus.out_op_b, 32'd0);

        // add x3,x1,x2 accepted while x1 is written
        step(); send(32'h002081B3, 32'h104);
        wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h1234;
        step(); bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        wb_addr = 5'd2; wb_data = 32'd7;        // stall cycle 1, writes x2
        @(negedge clk);
        check("byp_op_a", bus.out_op_a, 32'h1234);
        check("byp_funct7_5", 32'(bus.out_funct7_5), 32'd0);
        check("stall1_op_b_old", bus.out_op_b, 32'd20);
        check("stall1_in_ready", 32'(bus.in_ready), 32'd0);
        step(); wb_we = 1'b0;                   // stall cycle 2
        @(negedge clk);
        check("stall2_op_b", bus.out_op_b, 32'd7);
        check("stall2_pc", bus.out_pc, 32'h104);
        check("stall2_rd", 32'(bus.out_rd), 32'd3);
        step();                                 // stall cycle 3
        @(negedge clk);
        check("stall3_op_b", bus.out_op_b, 32'd7);
        check("stall3_imm", bus.out_imm, 32'd0);
        step(); bus.out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", 32'(bus.out_valid), 32'd1);
        step();
        @(negedge clk);
        check("drained_valid", 32'(bus.out_valid), 32'd0);

        // flush with a full stage and a ready incoming instruction
        step(); send(32'h00108313, 32'h108); bus.out_ready = 1'b0;
        step(); send(32'h00210393, 32'h10C); bus.out_ready = 1'b1; flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 32'(bus.in_ready), 32'd1);
        step(); flush = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        step();
        @(negedge clk);
        check("flush_dropped", 32'(bus.out_valid), 32'd0);

        // back-to-back formats: illegal, beq, lui, sw, jal
        step(); send(32'h00000000, 32'h200);
        step(); send(32'hFE000EE3, 32'h204);
        @(negedge clk);
        check("ill_illegal", 32'(bus.out_illegal), 32'd1);
        check("ill_class", 32'(bus.out_op_class), 32'd15);
        check("ill_rd", 32'(bus.out_rd), 32'd0);
        check("ill_imm", bus.out_imm, 32'd0);
        step(); send(32'hABCDE0B7, 32'h208);
        @(negedge clk);
        check("beq_imm", bus.out_imm, 32'hFFFFFFFC);
        check("beq_class", 32'(bus.out_op_class), 32'd4);
        check("beq_rd", 32'(bus.out_rd), 32'd0);
        step(); send(32'h0020A423, 32'h20C);
        @(negedge clk);
        check("lui_imm", bus.out_imm, 32'hABCDE000);
        check("lui_rd", 32'(bus.out_rd), 32'd1);
        step(); send(32'h008000EF, 32'h210);
        @(negedge clk);
        check("sw_imm", bus.out_imm, 32'd8);
        check("sw_op_b", bus.out_op_b, 32'd7);
        step(); bus.in_valid = 1'b0;
        @(negedge clk);
        check("jal_imm", bus.out_imm, 32'd8);
        check("jal_class", 32'(bus.out_op_class), 32'd5);

        // write to x0 is not bypassed
        step(); send(32'h00500413, 32'h220);
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD;
        step(); bus.in_valid = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        check("x0_op_a", bus.out_op_a, 32'd0);
        check("x0_imm", bus.out_imm, 32'd5);

        // reset pulsed during a stall
        step(); send(32'h002081B3, 32'h300); bus.out_ready = 1'b0;
        step(); bus.in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        step();
        #2 a_reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        #2 a_reset_n = 1'b1;
        step();
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
